// File: rtl/ula_arb_pkg.sv
// rtl/ula_arb_pkg.sv - shared types and ULA control encodings for the ULA arbiter
package ula_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arbState_t;

  localparam logic [1:0] OPALU_ADD   = 2'b00;
  localparam logic [1:0] OPALU_SUB   = 2'b01;
  localparam logic [1:0] OPALU_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef struct packed {
    logic [1:0]  opalu;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
  } ulaReq_t;

endpackage

// File: rtl/ula_arbiter_rr_arbiter.sv
// rtl/ula_arbiter_rr_arbiter.sv - combinational round-robin pick starting after lastGrant
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         reqVec,
  input  logic [$clog2(NREQ)-1:0] lastGrant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grantIdx
);

  localparam int IDX_W = $clog2(NREQ);
  localparam logic [IDX_W:0] NREQ_V = (IDX_W + 1)'(NREQ);

  logic [IDX_W:0]  shAmt;
  logic [IDX_W:0]  offs;
  logic [IDX_W:0]  sum;
  logic [NREQ-1:0] rot;
  logic            found;

  // Rotating a doubled copy puts requester lastGrant+1 at bit 0.
  always_comb begin
    shAmt    = {1'b0, lastGrant} + (IDX_W + 1)'(1);
    rot      = NREQ'({reqVec, reqVec} >> shAmt);
    found    = 1'b0;
    offs     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        offs  = (IDX_W + 1)'(i);
      end
    end
    sum      = shAmt + offs;
    grantIdx = (sum >= NREQ_V) ? IDX_W'(sum - NREQ_V) : IDX_W'(sum);
    grant    = found ? (NREQ'(1) << grantIdx) : '0;
  end

endmodule

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - round-robin sharing of one registered ULA among NREQ requesters
module ula_arbiter
  import ula_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ULA_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_opalu,
  input  logic [6*NREQ-1:0]    req_funct,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_result,
  output logic [1:0]           ula_opalu,
  output logic [5:0]           ula_funct,
  output logic [31:0]          ula_a,
  output logic [31:0]          ula_b,
  input  logic [31:0]          ula_result,
  output logic                 busy,
  output logic [CNT_W-1:0]     ops_done
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int WC_W  = $clog2(ULA_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  arbState_t        state, stateNext;
  logic [IDX_W-1:0] lastGrant;
  logic [IDX_W-1:0] grantIdx;
  logic [IDX_W-1:0] arbIdx;
  logic [NREQ-1:0]  arbGrant;
  logic [WC_W-1:0]  wcnt;
  logic             issue;
  logic             capture;
  logic             complete;
  ulaReq_t          selReq;
  ulaReq_t          ulaReg;
  logic [NREQ-1:0]  rspValidReg;
  logic [31:0]      rspResultReg;
  logic [CNT_W-1:0] opsDoneReg;

  rr_arbiter #(.NREQ(NREQ)) uArb (
    .reqVec    (req_valid),
    .lastGrant (lastGrant),
    .grant     (arbGrant),
    .grantIdx  (arbIdx)
  );

  always_comb begin
    selReq = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arbIdx == IDX_W'(i)) begin
        selReq.opalu = req_opalu[2*i +: 2];
        selReq.funct = req_funct[6*i +: 6];
        selReq.a     = req_a[32*i +: 32];
        selReq.b     = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // req_ready is only ever raised for a valid requester, so a grant is always a handshake.
  always_comb begin
    stateNext = state;
    req_ready = '0;
    issue     = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready = arbGrant;
          issue     = 1'b1;
          stateNext = WAIT;
        end
      end
      WAIT: begin
        if (wcnt == WC_W'(1)) begin
          capture   = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[grantIdx]) begin
          complete  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ulaReg       <= '0;
      grantIdx     <= '0;
      lastGrant    <= LAST_RST;
      wcnt         <= '0;
      rspValidReg  <= '0;
      rspResultReg <= '0;
      opsDoneReg   <= '0;
    end else begin
      if (issue) begin
        ulaReg   <= selReq;
        grantIdx <= arbIdx;
        wcnt     <= WC_W'(ULA_LAT);
      end else if (state == WAIT) begin
        wcnt <= wcnt - WC_W'(1);
      end
      if (capture) begin
        rspValidReg  <= NREQ'(1) << grantIdx;
        rspResultReg <= ula_result;
      end
      if (complete) begin
        rspValidReg <= '0;
        lastGrant   <= grantIdx;
        opsDoneReg  <= opsDoneReg + CNT_W'(1);
      end
    end
  end

  assign ula_opalu  = ulaReg.opalu;
  assign ula_funct  = ulaReg.funct;
  assign ula_a      = ulaReg.a;
  assign ula_b      = ulaReg.b;
  assign rsp_valid  = rspValidReg;
  assign rsp_result = rspResultReg;
  assign ops_done   = opsDoneReg;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - self-checking bench for ula_arbiter with a transaction-level reference model
module tb_ula_arbiter;
  import ula_arb_pkg::*;

  localparam int NREQ    = 3;
  localparam int ULA_LAT = 2;
  localparam int CNT_W   = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [2*NREQ-1:0]    req_opalu;
  logic [6*NREQ-1:0]    req_funct;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_result;
  logic [1:0]           ula_opalu;
  logic [5:0]           ula_funct;
  logic [31:0]          ula_a;
  logic [31:0]          ula_b;
  logic [31:0]          ula_result;
  logic                 busy;
  logic [CNT_W-1:0]     ops_done;

  ula_arbiter #(.NREQ(NREQ), .ULA_LAT(ULA_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opalu(req_opalu), .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .ula_opalu(ula_opalu), .ula_funct(ula_funct), .ula_a(ula_a), .ula_b(ula_b),
    .ula_result(ula_result), .busy(busy), .ops_done(ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] aluFn(input logic [1:0] op, input logic [5:0] fn,
                                        input logic [31:0] a, input logic [31:0] b);
    if (op == OPALU_ADD) return a + b;
    if (op == OPALU_SUB) return a - b;
    if (op == OPALU_RTYPE) begin
      case (fn)
        FUNCT_ADD: return a + b;
        FUNCT_SUB: return a - b;
        FUNCT_AND: return a & b;
        FUNCT_OR:  return a | b;
        FUNCT_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default:   return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  // Registered ULA: one register stage gives a two-edge latency from the ula_* inputs.
  logic [31:0] ulaQ = '0;
  always @(posedge clk) ulaQ <= aluFn(ula_opalu, ula_funct, ula_a, ula_b);
  assign ula_result = ulaQ;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, described by who holds it and when it answers.
  bit          mBusy;
  int          mGrant, mLast, mRspAt, mOps, cyc;
  logic [1:0]  mOp;
  logic [5:0]  mFn;
  logic [31:0] mA, mB, mResult;

  int              hsIdx;
  logic [NREQ-1:0] obsReady, obsRspV;
  logic [31:0]     obsResult;
  int              obsCyc;

  task automatic modelReset();
    mBusy = 0; mGrant = 0; mLast = NREQ - 1; mRspAt = 0; mOps = 0;
    mOp = '0; mFn = '0; mA = '0; mB = '0; mResult = '0;
  endtask

  function automatic int rrPick();
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (mLast + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic cycle();
    int g;
    bit rspOn, rspTake;
    logic [NREQ-1:0] expReady, expRspV;
    logic [1:0] op; logic [5:0] fn; logic [31:0] a, b;
    @(negedge clk);
    g = mBusy ? -1 : rrPick();
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    rspOn = mBusy && (cyc >= mRspAt);
    expRspV = '0;
    if (rspOn) expRspV[mGrant] = 1'b1;
    chk("req_ready", req_ready, expReady);
    chk("rsp_valid", rsp_valid, expRspV);
    chk("busy", busy, mBusy);
    chk("ops_done", ops_done, mOps % (1 << CNT_W));
    chk("ula_ctl", {ula_opalu, ula_funct}, {mOp, mFn});
    chk("ula_a", ula_a, mA);
    chk("ula_b", ula_b, mB);
    if (rspOn) chk("rsp_result", rsp_result, mResult);
    obsReady = req_ready; obsRspV = rsp_valid; obsResult = rsp_result; obsCyc = cyc;
    hsIdx = g;
    rspTake = rspOn && rsp_ready[mGrant];
    if (g >= 0) begin
      op = req_opalu[g*2 +: 2]; fn = req_funct[g*6 +: 6];
      a = req_a[g*32 +: 32];    b = req_b[g*32 +: 32];
    end
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      mBusy = 1; mGrant = g; mRspAt = cyc + ULA_LAT;
      mOp = op; mFn = fn; mA = a; mB = b; mResult = aluFn(op, fn, a, b);
    end else if (rspTake) begin
      mBusy = 0; mLast = mGrant; mOps++;
    end
    #1;
  endtask

  task automatic setReq(input int i, input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
    req_opalu[i*2 +: 2] = op; req_funct[i*6 +: 6] = fn;
    req_a[i*32 +: 32] = a;    req_b[i*32 +: 32] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic doReset();
    req_valid = '0;
    rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ops_done", ops_done, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_ula_ctl", {ula_opalu, ula_funct}, 0);
    chk("rst_ula_a", ula_a, 0);
    chk("rst_ula_b", ula_b, 0);
    modelReset();
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitGrant(input int expIdx, input int budget);
    for (int n = 0; n < budget; n++) begin
      cycle();
      if (obsReady != 0) break;
    end
    chk("grant_idx", obsReady, 1 << expIdx);
  endtask

  task automatic waitRsp(input int idx, input int budget);
    for (int n = 0; n < budget; n++) begin
      cycle();
      if (obsRspV != 0) break;
    end
    chk("rsp_owner", obsRspV, 1 << idx);
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 20; n++) begin
      if (!mBusy) break;
      cycle();
    end
    chk("drain_idle", busy, 0);
  endtask

  function automatic logic [5:0] randFunct();
    case ($urandom_range(5))
      0: return FUNCT_ADD;
      1: return FUNCT_SUB;
      2: return FUNCT_AND;
      3: return FUNCT_OR;
      4: return FUNCT_SLT;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int hs[$];
    logic [31:0] holdRes, holdA;
    rst_n = 1'b1; req_valid = '0; rsp_ready = '0;
    req_opalu = '0; req_funct = '0; req_a = '0; req_b = '0;
    cyc = 0; hsIdx = -1; modelReset();
    @(posedge clk); #1;
    doReset();

    // Single R-type ADD from requester 0
    rsp_ready = '1;
    setReq(0, OPALU_RTYPE, FUNCT_ADD, 32'd5, 32'd7);
    waitGrant(0, 3);
    c0 = obsCyc;
    req_valid[0] = 1'b0;
    waitRsp(0, 10);
    chk("t1_latency", obsCyc - c0, 3);
    chk("t1_result", obsResult, 32'd12);
    chk("t1_ops_done", ops_done, 1);

    // Contention from reset, then a repeat request from requester 0
    doReset();
    rsp_ready = '1;
    setReq(0, OPALU_SUB, 6'd0, 32'd9, 32'd4);
    setReq(1, OPALU_RTYPE, FUNCT_SUB, 32'd3, 32'd8);
    waitGrant(0, 3);
    setReq(0, OPALU_ADD, 6'd0, 32'd1, 32'd1);
    waitRsp(0, 10);
    chk("t2_res0", obsResult, 32'd5);
    waitGrant(1, 3);
    req_valid[1] = 1'b0;
    waitRsp(1, 10);
    chk("t2_res1", obsResult, 32'hFFFF_FFFB);
    waitGrant(0, 3);
    req_valid[0] = 1'b0;
    waitRsp(0, 10);
    chk("t2_res2", obsResult, 32'd2);
    waitIdle();

    // Response backpressure; other requesters' rsp_ready must be ignored
    rsp_ready = '0;
    setReq(0, OPALU_RTYPE, FUNCT_AND, $urandom, $urandom);
    setReq(1, OPALU_RTYPE, FUNCT_OR, $urandom, $urandom);
    waitGrant(1, 3);
    req_valid[1] = 1'b0;
    waitRsp(1, 10);
    holdRes = obsResult;
    holdA = ula_a;
    rsp_ready = 3'b101;
    repeat (5) begin
      cycle();
      chk("bp_valid", obsRspV, 3'b010);
      chk("bp_result", obsResult, holdRes);
      chk("bp_ready", obsReady, 0);
      chk("bp_ula_a", ula_a, holdA);
    end
    rsp_ready = '1;
    cycle();
    waitGrant(0, 3);
    req_valid[0] = 1'b0;
    waitRsp(0, 10);
    waitIdle();

    // Back-to-back on requester 0
    rsp_ready = '1;
    setReq(0, OPALU_ADD, 6'd0, 32'd100, 32'd23);
    for (int n = 0; n < 40 && hs.size() < 4; n++) begin
      cycle();
      if (obsReady[0]) hs.push_back(obsCyc);
    end
    req_valid[0] = 1'b0;
    chk("b2b_count", hs.size(), 4);
    for (int i = 1; i < hs.size(); i++) chk("b2b_gap", hs[i] - hs[i-1], ULA_LAT + 2);
    waitIdle();

    // Reset during WAIT discards the operation and restores round-robin origin
    setReq(1, OPALU_ADD, 6'd0, 32'd10, 32'd20);
    waitGrant(1, 3);
    req_valid[1] = 1'b0;
    cycle();
    doReset();
    cycle();
    chk("t5_no_rsp", obsRspV, 0);
    setReq(0, OPALU_SUB, 6'd0, 32'd50, 32'd8);
    setReq(1, OPALU_ADD, 6'd0, 32'd1, 32'd2);
    waitGrant(0, 3);
    req_valid = '0;
    waitRsp(0, 10);
    chk("t5_result", obsResult, 32'd42);
    waitIdle();

    // ops_done wraps at 2^CNT_W
    doReset();
    rsp_ready = '1;
    setReq(0, OPALU_ADD, 6'd0, 32'd1, 32'd2);
    hs.delete();
    for (int n = 0; n < 17 * (ULA_LAT + 2) + 10 && hs.size() < 17; n++) begin
      cycle();
      if (obsReady[0]) hs.push_back(obsCyc);
    end
    req_valid[0] = 1'b0;
    waitIdle();
    chk("wrap_ops_done", ops_done, 1);

    // Randomized traffic
    doReset();
    for (int n = 0; n < 1500; n++) begin
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (hsIdx == i) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(15) == 0) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(2) == 0)
          setReq(i, 2'($urandom_range(3)), randFunct(), $urandom, $urandom);
      end
      rsp_ready = NREQ'($urandom);
    end
    req_valid = '0;
    rsp_ready = '1;
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Shares one registered ULA datapath (ULA plus ULAControl, both clocked on `clk`) among `NREQ` requesters. Each request carries `OpALU`, `funct` and two 32-bit operands. The block picks one requester round-robin, drives the ULA inputs, waits the fixed ULA latency, and returns the result to the granted requester over a valid/ready response channel. Only one operation is in flight at a time; the block is not pipelined.

## Interface
- `NREQ`, default 2: number of requesters, range 2..8.
- `ULA_LAT`, default 2: clock edges from the ULA inputs changing to `ula_result` being valid, range ≥1.
- `CNT_W`, default 16: width of the completed-operation counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: bit i is asserted by requester i while it holds a request.
- `req_ready`  out  NREQ: one-hot; the request completes on `req_valid[i] & req_ready[i]`.
- `req_opalu`  in  2*NREQ: slice i is requester i's OpALU.
- `req_funct`  in  6*NREQ: slice i is requester i's funct.
- `req_a`, `req_b`  in  32*NREQ: slice i is requester i's operands.
- `rsp_valid`  out  NREQ: one-hot; the result is valid for that requester.
- `rsp_ready`  in  NREQ: bit i is asserted when requester i accepts its result.
- `rsp_result`  out  32: result, meaningful only while `rsp_valid` is nonzero.
- `ula_opalu`  out  2, `ula_funct`  out  6, `ula_a`  out  32, `ula_b`  out  32: registered drive to the ULA.
- `ula_result`  in  32: ULA output.
- `busy`  out  1: high whenever the state is not IDLE.
- `ops_done`  out  CNT_W: count of completed responses; wraps modulo 2^CNT_W.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - If any `req_valid` is set, the winner g is the first set bit searching upward from `last_grant+1`, wrapping modulo NREQ.
  - `req_ready[g]` is driven high combinationally in the same cycle. All other `req_ready` bits stay 0.
  - On the handshake, slice g is registered into the `ula_*` outputs, g is latched, `wcnt` is loaded with `ULA_LAT`, and the state goes to WAIT.
  - With no valid request, the state stays in IDLE and `req_ready` is 0.
- **WAIT**
  - `wcnt` decrements every cycle.
  - In the cycle where `wcnt == 1`: `ula_result` is registered into `rsp_result`, `rsp_valid[g]` is set at the next edge, and the state goes to RESP.
- **RESP**
  - `rsp_valid[g]` and `rsp_result` are held until `rsp_ready[g]` is high.
  - On `rsp_valid[g] & rsp_ready[g]`:
    - `rsp_valid` clears.
    - `last_grant` is set to g.
    - `ops_done` increments.
    - The state goes to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- The `ula_*` outputs hold their last issued values outside the issue edge. They are never changed during WAIT or RESP.
- Requesters must hold their request slice stable while `req_valid` is high. The block samples it only on the handshake edge.

## Timing
- Reset values (asynchronous): state IDLE, `last_grant = NREQ-1` (so requester 0 wins first), all outputs 0, `wcnt` 0, `ops_done` 0.
- Latency, with the handshake in cycle 0:
  - `ula_*` are updated at the end of cycle 0.
  - WAIT occupies cycles 1..ULA_LAT.
  - `rsp_valid` is high from cycle ULA_LAT+1.
  - With the defaults, `rsp_valid` rises in cycle 3.
- Back-to-back: `rsp_ready` high in the first RESP cycle gives IDLE in the following cycle, where the next handshake can occur. Peak throughput is one operation per ULA_LAT+2 cycles.
- Simultaneous requests are resolved round-robin. A requester that keeps `req_valid` high is never starved: it wins within NREQ grants.
- A request that arrives while `busy` waits; `req_ready` stays 0 until IDLE.
- Dropping `req_valid` before the handshake is legal; that requester is not granted.
- Deasserting `rst_n` mid-operation discards the operation with no response issued. `last_grant` returns to NREQ-1.
- With `ULA_LAT = 1`, WAIT lasts exactly one cycle.

## Structure
- Package `ula_arb_pkg`:
  - state enum (IDLE, WAIT, RESP);
  - OpALU constants: `OPALU_ADD = 2'b00`, `OPALU_SUB = 2'b01`, `OPALU_RTYPE = 2'b10`;
  - funct constants used by the bench: ADD `100000`, SUB `100010`, AND `100100`, OR `100101`, SLT `101010`.
- One sub-module, `rr_arbiter`: combinational, NREQ-wide. Inputs are the request vector and `last_grant`; outputs are a one-hot grant and its index.

## Test plan
- Single request, R-type ADD: requester 0 sends OpALU=10, funct=100000, a=5, b=7 -> `req_ready[0]` in cycle 0, `rsp_valid[0]` in cycle 3, `rsp_result` = 12, `ops_done` = 1.
- Contention: both requesters valid from reset with SUB 9-4 and SUB 3-8 -> requester 0 served first with result 5, then requester 1 with result 0xFFFFFFFB. A third request from requester 0 is served only after requester 1's.
- Response backpressure: `rsp_ready` held low for 5 cycles -> `rsp_valid` and `rsp_result` stay stable. `ula_*` unchanged, `req_ready` stays 0, no second grant.
- Back-to-back on one requester with `rsp_ready` tied high -> consecutive `req_ready` pulses exactly 4 cycles apart.
- Reset in WAIT: `rst_n` low for 1 cycle during cycle 2 -> no `rsp_valid`, all outputs 0, `ops_done` 0, and requester 0 wins the next arbitration.
- `ops_done` wrap with CNT_W=4: 17 operations -> `ops_done` = 1.
